// File: rtl/fft4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft4_pkg
//  Description : Shared constants and helpers for the 4-point DIT FFT pipe:
//                mode encoding, output-width derivation and lane extraction
//                for packed multi-lane buses.
//  Revision    : 1.0  initial release
// ============================================================================
package fft4_pkg;

    localparam logic MODE_FFT  = 1'b0;
    localparam logic MODE_IFFT = 1'b1;

    // Full-growth output width: two radix-2 stages add one bit each.
    function automatic int fft4_ow(input int iw);
        return iw + 2;
    endfunction

    // Unsigned lane k of width w from a packed bus (up to 128 bits, w <= 32).
    function automatic logic [31:0] lane_get(input logic [127:0] bus, input int k, input int w);
        logic [127:0] t;
        t = bus >> (k * w);
        t = t & ((128'd1 << w) - 128'd1);
        return t[31:0];
    endfunction

    // Sign-extended lane k of width w from a packed bus (w <= 32).
    function automatic int lane_sx(input logic [127:0] bus, input int k, input int w);
        logic [127:0] t;
        t = bus >> (k * w);
        t = t << (128 - w);
        t = $signed(t) >>> (128 - w);
        return int'(t[31:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft4_dit_pipe_cbfly2.sv
`default_nettype none
// ============================================================================
//  Module      : cbfly2
//  Description : Combinational radix-2 complex butterfly. Produces p = a + b
//                and m = a - b with one bit of growth (W+1), so no overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module cbfly2 #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_re,
    input  logic [W-1:0] a_im,
    input  logic [W-1:0] b_re,
    input  logic [W-1:0] b_im,
    output logic [W:0]   p_re,
    output logic [W:0]   p_im,
    output logic [W:0]   m_re,
    output logic [W:0]   m_im
);

    // Sign-extend both operands by one bit, then add/subtract at W+1.
    assign p_re = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    assign p_im = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    assign m_re = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    assign m_im = {a_im[W-1], a_im} - {b_im[W-1], b_im};

endmodule
`default_nettype wire

// File: rtl/fft4_dit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fft4_dit_pipe
//  Description : Two-stage pipelined 4-point radix-2 DIT complex FFT/IFFT.
//                Stage 1 forms the length-2 sums/differences, stage 2 applies
//                the +/-j twiddle and the final butterflies, with optional /4
//                scaling of inverse results. Valid/ready on both sides with a
//                combinational ready chain (no skid buffer).
//  Revision    : 1.0  initial release
// ============================================================================
module fft4_dit_pipe
    import fft4_pkg::*;
#(
    parameter int IW         = 4,
    parameter int OW         = fft4_ow(IW),
    parameter bit SCALE_IFFT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_inv,
    input  logic [4*IW-1:0] in_re,
    input  logic [4*IW-1:0] in_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_inv,
    output logic [4*OW-1:0] out_re,
    output logic [4*OW-1:0] out_im
);

    localparam int SW = IW + 1;

    logic [IW-1:0] w_x_re [4];
    logic [IW-1:0] w_x_im [4];
    logic [SW-1:0] w_s_re [4];
    logic [SW-1:0] w_s_im [4];
    logic [SW-1:0] w_rot_re;
    logic [SW-1:0] w_rot_im;
    logic [OW-1:0] w_y_re [4];
    logic [OW-1:0] w_y_im [4];
    logic [OW-1:0] w_z_re [4];
    logic [OW-1:0] w_z_im [4];
    logic          w_adv1;
    logic          w_adv2;
    logic          w_scale;

    logic          r_v1;
    logic          r_inv1;
    logic [SW-1:0] r_s_re [4];
    logic [SW-1:0] r_s_im [4];
    logic          r_v2;
    logic          r_inv2;
    logic [OW-1:0] r_x_re [4];
    logic [OW-1:0] r_x_im [4];

    // A stage may advance when its successor is empty or itself advancing.
    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;

    // Unpack input lanes and repack output lanes.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_x_re[k]          = in_re[k*IW +: IW];
        assign w_x_im[k]          = in_im[k*IW +: IW];
        assign out_re[k*OW +: OW] = r_x_re[k];
        assign out_im[k*OW +: OW] = r_x_im[k];
    end

    // Stage 1: (x0,x2) -> s0,s1 and (x1,x3) -> s2,s3.
    for (genvar b = 0; b < 2; b++) begin : g_s1
        cbfly2 #(.W(IW)) u_bf (
            .a_re (w_x_re[b]),
            .a_im (w_x_im[b]),
            .b_re (w_x_re[b+2]),
            .b_im (w_x_im[b+2]),
            .p_re (w_s_re[2*b]),
            .p_im (w_s_im[2*b]),
            .m_re (w_s_re[2*b+1]),
            .m_im (w_s_im[2*b+1])
        );
    end

    // Twiddle on s3: forward uses -j*s3 = (i, -r), inverse uses +j*s3 = (-i, r).
    // |s3| <= 2^IW - 1, so negation at SW bits cannot overflow.
    assign w_rot_re = (r_inv1 == MODE_IFFT) ? -r_s_im[3] : r_s_im[3];
    assign w_rot_im = (r_inv1 == MODE_IFFT) ? r_s_re[3]  : -r_s_re[3];

    // Stage 2 even bins: X0 = s0 + s2, X2 = s0 - s2.
    cbfly2 #(.W(SW)) u_bf_even (
        .a_re (r_s_re[0]),
        .a_im (r_s_im[0]),
        .b_re (r_s_re[2]),
        .b_im (r_s_im[2]),
        .p_re (w_y_re[0]),
        .p_im (w_y_im[0]),
        .m_re (w_y_re[2]),
        .m_im (w_y_im[2])
    );

    // Stage 2 odd bins: X1 = s1 + rot(s3), X3 = s1 - rot(s3).
    cbfly2 #(.W(SW)) u_bf_odd (
        .a_re (r_s_re[1]),
        .a_im (r_s_im[1]),
        .b_re (w_rot_re),
        .b_im (w_rot_im),
        .p_re (w_y_re[1]),
        .p_im (w_y_im[1]),
        .m_re (w_y_re[3]),
        .m_im (w_y_im[3])
    );

    // Inverse frames optionally floor-divided by 4; forward frames never scaled.
    assign w_scale = SCALE_IFFT && (r_inv1 == MODE_IFFT);

    for (genvar k = 0; k < 4; k++) begin : g_scale
        assign w_z_re[k] = w_scale ? {{2{w_y_re[k][OW-1]}}, w_y_re[k][OW-1:2]} : w_y_re[k];
        assign w_z_im[k] = w_scale ? {{2{w_y_im[k][OW-1]}}, w_y_im[k][OW-1:2]} : w_y_im[k];
    end

    // Stage 1 register bank: valid follows the input slot, data only on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_inv1 <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_s_re[k] <= '0;
                r_s_im[k] <= '0;
            end
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_inv1 <= in_inv;
                for (int k = 0; k < 4; k++) begin
                    r_s_re[k] <= w_s_re[k];
                    r_s_im[k] <= w_s_im[k];
                end
            end
        end
    end

    // Stage 2 register bank: holds while stalled so out_* stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_inv2 <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_x_re[k] <= '0;
                r_x_im[k] <= '0;
            end
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_inv2 <= r_inv1;
                for (int k = 0; k < 4; k++) begin
                    r_x_re[k] <= w_z_re[k];
                    r_x_im[k] <= w_z_im[k];
                end
            end
        end
    end

    assign out_valid = r_v2;
    assign out_inv   = r_inv2;

endmodule
`default_nettype wire

// File: tb/tb_fft4_dit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft4_dit_pipe
//  Description : Directed self-checking bench for fft4_dit_pipe (IW=4).
//                Second instance built with inverse scaling enabled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft4_dit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_inv;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_inv;
    logic [23:0] out_re,    out_im;
    logic        in_ready_s, out_valid_s, out_inv_s;
    logic [23:0] out_re_s,  out_im_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fft4_dit_pipe #(.IW(4), .SCALE_IFFT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_re(in_re), .in_im(in_im), .out_valid(out_valid),
        .out_ready(out_ready), .out_inv(out_inv), .out_re(out_re), .out_im(out_im)
    );

    fft4_dit_pipe #(.IW(4), .SCALE_IFFT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_inv(in_inv), .in_re(in_re), .in_im(in_im), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_inv(out_inv_s), .out_re(out_re_s), .out_im(out_im_s)
    );

    function automatic logic [15:0] pack_i(input int v[4]);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(v[k]);
        return r;
    endfunction

    function automatic logic [23:0] pack_o(input int v[4]);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*6 +: 6] = 6'(v[k]);
        return r;
    endfunction

    // Direct 4-point DFT: X[k] = sum x[n] * w^(n*k), w = -j (forward) or +j (inverse).
    function automatic void gold(input int xr[4], input int xi[4], input bit inv, input bit scl,
                                 output int yr[4], output int yi[4]);
        int ar, ai, m;
        for (int k = 0; k < 4; k++) begin
            ar = 0; ai = 0;
            for (int n = 0; n < 4; n++) begin
                m = (n * k) % 4;
                if (inv) m = (4 - m) % 4;
                case (m)
                    0: begin ar += xr[n]; ai += xi[n]; end
                    1: begin ar += xi[n]; ai -= xr[n]; end
                    2: begin ar -= xr[n]; ai -= xi[n]; end
                    default: begin ar -= xi[n]; ai += xr[n]; end
                endcase
            end
            if (inv && scl) begin ar = ar >>> 2; ai = ai >>> 2; end
            yr[k] = ar; yi[k] = ai;
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_inv !== 1'b0) begin n_bad++; $display("FAIL reset_out_inv got=%b exp=0", out_inv); end
        n_cmp++; if (out_re !== 24'h0 || out_im !== 24'h0) begin
            n_bad++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_re, out_im);
        end
    endtask

    // Frame 1,2,3,4 (real) forward: checks 2-cycle latency and both instances unscaled.
    task automatic test_fft();
        int xr[4], xi[4], er[4], ei[4];
        xr = '{1, 2, 3, 4}; xi = '{0, 0, 0, 0};
        er = '{10, -2, -2, -2}; ei = '{0, 2, 0, -2};
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b0; in_re = pack_i(xr); in_im = pack_i(xi);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fft_lat1 out_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fft_lat2 out_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_re !== pack_o(er) || out_im !== pack_o(ei)) begin
            n_bad++; $display("FAIL fft_data got=%h/%h exp=%h/%h", out_re, out_im, pack_o(er), pack_o(ei));
        end
        n_cmp++; if (out_inv !== 1'b0) begin n_bad++; $display("FAIL fft_inv got=%b exp=0", out_inv); end
        n_cmp++; if (out_re_s !== pack_o(er) || out_im_s !== pack_o(ei)) begin
            n_bad++; $display("FAIL fft_noscale got=%h/%h exp=%h/%h", out_re_s, out_im_s, pack_o(er), pack_o(ei));
        end
        @(negedge clk);
    endtask

    // Same frame inverse: unscaled and /4-floored instances.
    task automatic test_ifft();
        int xr[4], xi[4], er[4], ei[4], sr[4], si[4];
        xr = '{1, 2, 3, 4}; xi = '{0, 0, 0, 0};
        er = '{10, -2, -2, -2}; ei = '{0, -2, 0, 2};
        sr = '{2, -1, -1, -1};  si = '{0, -1, 0, 0};
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b1; in_re = pack_i(xr); in_im = pack_i(xi);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_inv !== 1'b1) begin
            n_bad++; $display("FAIL ifft_valid_inv got=%b%b exp=11", out_valid, out_inv);
        end
        n_cmp++; if (out_re !== pack_o(er) || out_im !== pack_o(ei)) begin
            n_bad++; $display("FAIL ifft_data got=%h/%h exp=%h/%h", out_re, out_im, pack_o(er), pack_o(ei));
        end
        n_cmp++; if (out_re_s !== pack_o(sr) || out_im_s !== pack_o(si)) begin
            n_bad++; $display("FAIL ifft_scaled got=%h/%h exp=%h/%h", out_re_s, out_im_s, pack_o(sr), pack_o(si));
        end
        @(negedge clk);
    endtask

    // Full-scale inputs: all -8 and all +7, back to back.
    task automatic test_extremes();
        int xn[4], xp[4], enr[4], epr[4];
        xn = '{-8, -8, -8, -8}; xp = '{7, 7, 7, 7};
        enr = '{-32, 0, 0, 0};  epr = '{28, 0, 0, 0};
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b0; in_re = pack_i(xn); in_im = pack_i(xn);
        @(negedge clk);
        in_re = pack_i(xp); in_im = pack_i(xp);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_re !== pack_o(enr) || out_im !== pack_o(enr)) begin
            n_bad++; $display("FAIL ext_neg got=%h/%h exp=%h/%h", out_re, out_im, pack_o(enr), pack_o(enr));
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_re !== pack_o(epr) || out_im !== pack_o(epr)) begin
            n_bad++; $display("FAIL ext_pos got=%b %h/%h exp=1 %h/%h", out_valid, out_re, out_im, pack_o(epr), pack_o(epr));
        end
        @(negedge clk);
    endtask

    // Six frames at full rate with out_ready low on cycles 2..4.
    task automatic test_back_to_back();
        int fre[6][4] = '{'{1, 2, 3, 4}, '{-8, 7, -1, 0}, '{3, 3, 3, 3},
                          '{0, -5, 6, -7}, '{7, -8, 7, -8}, '{2, 0, -3, 5}};
        int fim[6][4] = '{'{0, 0, 0, 0}, '{1, -2, 3, -4}, '{-8, -8, 7, 7},
                          '{5, 0, -5, 0}, '{-1, -1, -1, -1}, '{6, -6, 4, -4}};
        bit finv[6] = '{0, 1, 0, 1, 1, 0};
        int xr[4], xi[4], er[4], ei[4];
        int sent, recv, cyc;
        bit hold, saw_block;
        logic [23:0] hold_re, hold_im;
        sent = 0; recv = 0; cyc = 0; hold = 0; saw_block = 0; hold_re = '0; hold_im = '0;
        while (recv < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (sent < 6) begin
                for (int j = 0; j < 4; j++) begin xr[j] = fre[sent][j]; xi[j] = fim[sent][j]; end
                in_valid = 1'b1; in_inv = finv[sent]; in_re = pack_i(xr); in_im = pack_i(xi);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold) begin
                n_cmp++; if (out_valid !== 1'b1 || out_re !== hold_re || out_im !== hold_im) begin
                    n_bad++; $display("FAIL b2b_hold cyc=%0d got=%b %h/%h exp=1 %h/%h", cyc, out_valid, out_re, out_im, hold_re, hold_im);
                end
            end
            n_cmp++; if (!in_ready && !(out_valid && !out_ready)) begin
                n_bad++; $display("FAIL b2b_in_ready cyc=%0d got=0 exp=1", cyc);
            end
            if (!in_ready) saw_block = 1;
            hold = out_valid && !out_ready; hold_re = out_re; hold_im = out_im;
            if (out_valid && out_ready) begin
                for (int j = 0; j < 4; j++) begin xr[j] = fre[recv][j]; xi[j] = fim[recv][j]; end
                gold(xr, xi, finv[recv], 1'b0, er, ei);
                n_cmp++; if (out_re !== pack_o(er) || out_im !== pack_o(ei) || out_inv !== finv[recv]) begin
                    n_bad++; $display("FAIL b2b_frame%0d got=%h/%h inv=%b exp=%h/%h inv=%b", recv, out_re, out_im, out_inv, pack_o(er), pack_o(ei), finv[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        n_cmp++; if (recv != 6) begin n_bad++; $display("FAIL b2b_count got=%0d exp=6", recv); end
        n_cmp++; if (!saw_block) begin n_bad++; $display("FAIL b2b_backpressure in_ready_low got=0 exp=1"); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Alternating mode per frame at full rate; each output lands exactly 2 cycles later.
    task automatic test_alt_mode();
        int fre[4][4] = '{'{1, -3, 5, 2}, '{1, -3, 5, 2}, '{0, 4, -4, 6}, '{0, 4, -4, 6}};
        int fim[4][4] = '{'{2, 7, -1, -6}, '{2, 7, -1, -6}, '{-7, 3, 1, 5}, '{-7, 3, 1, 5}};
        bit finv[4] = '{0, 1, 0, 1};
        int xr[4], xi[4], er[4], ei[4];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                for (int j = 0; j < 4; j++) begin xr[j] = fre[c][j]; xi[j] = fim[c][j]; end
                in_valid = 1'b1; in_inv = finv[c]; in_re = pack_i(xr); in_im = pack_i(xi);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 2) begin
                for (int j = 0; j < 4; j++) begin xr[j] = fre[c-2][j]; xi[j] = fim[c-2][j]; end
                gold(xr, xi, finv[c-2], 1'b0, er, ei);
                n_cmp++; if (out_valid !== 1'b1 || out_inv !== finv[c-2] || out_re !== pack_o(er) || out_im !== pack_o(ei)) begin
                    n_bad++; $display("FAIL alt_frame%0d got=%b inv=%b %h/%h exp=1 inv=%b %h/%h", c-2, out_valid, out_inv, out_re, out_im, finv[c-2], pack_o(er), pack_o(ei));
                end
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset with two frames in flight, then a clean frame afterwards.
    task automatic test_reset_mid();
        int xr[4], xi[4], er[4], ei[4];
        bit stale;
        xr = '{3, -2, 6, 1}; xi = '{-4, 5, 0, 2};
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b1; in_re = pack_i(xr); in_im = pack_i(xi);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got=%b exp=1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_inv !== 1'b0 || out_re !== 24'h0 || out_im !== 24'h0) begin
            n_bad++; $display("FAIL rstmid_async got=%b %b %h/%h exp=0 0 0/0", out_valid, out_inv, out_re, out_im);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1;
        end
        n_cmp++; if (stale) begin n_bad++; $display("FAIL rstmid_stale got=1 exp=0"); end
        xr = '{-1, 4, 2, -6}; xi = '{3, 3, -8, 0};
        in_valid = 1'b1; in_inv = 1'b0; in_re = pack_i(xr); in_im = pack_i(xi);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_lat1 got=%b exp=0", out_valid); end
        @(negedge clk);
        gold(xr, xi, 1'b0, 1'b0, er, ei);
        n_cmp++; if (out_valid !== 1'b1 || out_re !== pack_o(er) || out_im !== pack_o(ei)) begin
            n_bad++; $display("FAIL rstmid_after got=%b %h/%h exp=1 %h/%h", out_valid, out_re, out_im, pack_o(er), pack_o(ei));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fft();
        test_ifft();
        test_extremes();
        test_back_to_back();
        test_alt_mode();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
